// File: rtl/mips_mem_pkg.sv
// Shared definitions for data-memory initiators: copy FSM states and
// word/byte addressing constants.
package mips_mem_pkg;

  typedef enum logic [2:0] {IDLE, CHK, RD, WR, FIN} dma_state_e;

  localparam int unsigned MEM_WORDS_DEF = 128;
  localparam int unsigned WORD_BYTES    = 4;
  localparam int unsigned ADDR_SHIFT    = 2;

  function automatic logic [31:0] word_index(input logic [31:0] byte_addr);
    return byte_addr >> ADDR_SHIFT;
  endfunction

endpackage

// File: rtl/mem_copy_range_chk.sv
// Alignment and bounds check for a word-run request against a memory of
// MEM_WORDS words; purely combinational so any initiator can reuse it.
module mem_copy_range_chk
  import mips_mem_pkg::*;
#(
  parameter int unsigned MEM_WORDS = MEM_WORDS_DEF,
  parameter int unsigned LEN_W     = 8
) (
  input  logic [31:0]      src_addr_i,
  input  logic [31:0]      dst_addr_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             err_o
);

  logic [33:0] src_end;
  logic [33:0] dst_end;
  logic        misaligned;

  // End indices are widened to 34 bits so a huge base plus length cannot wrap.
  always_comb begin
    src_end    = 34'(word_index(src_addr_i)) + 34'(len_i);
    dst_end    = 34'(word_index(dst_addr_i)) + 34'(len_i);
    misaligned = (src_addr_i[1:0] != 2'b00) || (dst_addr_i[1:0] != 2'b00);
    err_o      = misaligned || (src_end > 34'(MEM_WORDS)) || (dst_end > 34'(MEM_WORDS));
  end

endmodule

// File: rtl/mem_copy_dma.sv
// Word-by-word memory copy engine: one read cycle then one write cycle per
// word, ascending addresses, all outputs driven straight from registers.
module mem_copy_dma
  import mips_mem_pkg::*;
#(
  parameter int unsigned MEM_WORDS = MEM_WORDS_DEF,
  parameter int unsigned LEN_W     = 8
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             START,
  input  logic [31:0]      SRC_ADDR,
  input  logic [31:0]      DST_ADDR,
  input  logic [LEN_W-1:0] LEN,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR,
  output logic [31:0]      Address,
  output logic [31:0]      Write_Data,
  output logic             MemWrite,
  output logic             MemRead,
  input  logic [31:0]      Read_data
);

  localparam logic [31:0] STEP = 32'(WORD_BYTES);

  dma_state_e       state_q;
  logic [31:0]      src_q, dst_q, addr_q, hold_q;
  logic [LEN_W-1:0] len_q, cnt_q;
  logic [LEN_W:0]   cnt_d;
  logic             busy_q, done_q, err_q, rd_q, wr_q;
  logic             chk_err;

  mem_copy_range_chk #(
    .MEM_WORDS (MEM_WORDS),
    .LEN_W     (LEN_W)
  ) u_range_chk (
    .src_addr_i (src_q),
    .dst_addr_i (dst_q),
    .len_i      (len_q),
    .err_o      (chk_err)
  );

  assign cnt_d = {1'b0, cnt_q} + (LEN_W + 1)'(1);

  // Output registers are loaded on the transition into the state that owns
  // them; hold_q is cleared leaving WR so Write_Data is zero elsewhere.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      addr_q  <= '0;
      hold_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (START) begin
            src_q   <= SRC_ADDR;
            dst_q   <= DST_ADDR;
            len_q   <= LEN;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= CHK;
          end
        end
        CHK: begin
          if (chk_err || (len_q == '0)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= chk_err;
            state_q <= FIN;
          end else begin
            rd_q    <= 1'b1;
            addr_q  <= src_q;
            state_q <= RD;
          end
        end
        RD: begin
          hold_q  <= Read_data;
          rd_q    <= 1'b0;
          wr_q    <= 1'b1;
          addr_q  <= dst_q;
          state_q <= WR;
        end
        WR: begin
          src_q  <= src_q + STEP;
          dst_q  <= dst_q + STEP;
          cnt_q  <= cnt_d[LEN_W-1:0];
          wr_q   <= 1'b0;
          hold_q <= '0;
          if (cnt_d < {1'b0, len_q}) begin
            rd_q    <= 1'b1;
            addr_q  <= src_q + STEP;
            state_q <= RD;
          end else begin
            addr_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= FIN;
          end
        end
        FIN: begin
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign ERR        = err_q;
  assign MemRead    = rd_q;
  assign MemWrite   = wr_q;
  assign Address    = addr_q;
  assign Write_Data = hold_q;

endmodule

// File: doc/mem_copy_dma.md
MEM_COPY_DMA -- requirements
Module: mem_copy_dma

Interface
REQ-001 The block SHALL have the following parameters, one per line:
- MEM_WORDS, default 128: data memory depth in 32-bit words.
- LEN_W, default 8: width of the transfer-length input.
REQ-002 The block SHALL have the following ports, one per line:
- CLK  in  1  single clock; all state changes on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- START  in  1  request a copy; sampled only in IDLE.
- SRC_ADDR  in  32  source byte address, word aligned.
- DST_ADDR  in  32  destination byte address, word aligned.
- LEN  in  LEN_W  number of words to copy.
- BUSY  out  1  high from the cycle after accepted START until DONE.
- DONE  out  1  one-cycle completion pulse.
- ERR  out  1  one-cycle pulse coincident with DONE when the request was rejected.
- Address  out  32  memory byte address.
- Write_Data  out  32  memory write data.
- MemWrite  out  1  memory write strobe; memory commits on the CLK rising edge.
- MemRead  out  1  memory read enable.
- Read_data  in  32  combinational memory read data, valid in the same cycle as MemRead/Address.

Function
REQ-003 The block SHALL be the initiator for the data memory: it copies LEN consecutive words from SRC_ADDR to DST_ADDR in ascending address order.
REQ-004 The FSM SHALL have states IDLE, CHK, RD, WR, FIN; state changes occur on rising CLK edges only.
REQ-005 In IDLE with START=1, the block SHALL latch SRC_ADDR, DST_ADDR and LEN, clear the word counter, and go to CHK; START at any other time SHALL be ignored.
REQ-006 CHK SHALL reject the request (ERR=1 in FIN) when any of the following holds, and then go to FIN with no memory access:
- SRC_ADDR[1:0]≠0 or DST_ADDR[1:0]≠0;
- (SRC_ADDR>>2)+LEN > MEM_WORDS or (DST_ADDR>>2)+LEN > MEM_WORDS, computed at 33+ bits with no wrap.
REQ-007 In CHK, LEN=0 SHALL go to FIN with ERR=0 and no memory access; a valid LEN>0 SHALL go to RD.
REQ-008 In RD the block SHALL drive Address=src_ptr, MemRead=1 and MemWrite=0, capture Read_data into a 32-bit holding register at the cycle end, and go to WR.
REQ-009 In WR the block SHALL drive Address=dst_ptr, Write_Data=holding register, MemWrite=1 and MemRead=0; at the cycle end it SHALL add 4 to both pointers and increment the counter.
REQ-010 After WR the block SHALL go to RD if counter+1 < LEN, otherwise to FIN.
REQ-011 In FIN the block SHALL assert DONE=1 for exactly one cycle, with ERR per REQ-006, and then return to IDLE.
REQ-012 Outside RD and WR, MemRead, MemWrite, Address and Write_Data SHALL all be 0; MemRead and MemWrite SHALL never be high together.
REQ-013 BUSY SHALL be 1 in CHK, RD and WR, and 0 in IDLE and FIN.
REQ-014 All outputs SHALL be decoded from registered state only, with no combinational path from any input.
REQ-015 A valid copy SHALL take 2·LEN+2 cycles from the START edge to the DONE cycle.
REQ-016 For overlapping regions the block SHALL perform a plain ascending copy with no overlap correction; with DST>SRC this propagates already-copied words.
REQ-017 A START held high through FIN SHALL be accepted again in the following IDLE cycle.

Reset
REQ-018 When RESET_N=0, the block SHALL immediately, without waiting for CLK, go to IDLE and drive BUSY=DONE=ERR=MemRead=MemWrite=0 and Address=Write_Data=0.
REQ-019 When RESET_N=0, the block SHALL clear the pointers, counter and holding register.
REQ-020 A reset during RD or WR SHALL abort the copy with no DONE pulse; words already written remain in memory.

Structure
REQ-021 A shared package mips_mem_pkg SHALL hold the state enum, the default MEM_WORDS=128, WORD_BYTES=4, and the address-to-word-index shift.
REQ-022 The range and alignment check SHALL be one combinational sub-module, mem_copy_range_chk, reusable by other memory initiators; everything else stays in mem_copy_dma.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Memory words 0..2 = 43, 21, 34; START with SRC=0, DST=0x50, LEN=3 -> words 20..22 = 43, 21, 34; DONE at cycle 8 after START; ERR=0; exactly 3 MemWrite pulses.
- LEN=0 -> DONE 2 cycles after START; ERR=0; no MemRead/MemWrite.
- SRC=0x02 -> DONE+ERR 2 cycles after START; no memory access.
- DST=0x1FC, LEN=2 -> DONE+ERR 2 cycles after START; no memory access.
- Words 0..3 = 1, 2, 3, 4; SRC=0, DST=4, LEN=3 -> words 0..3 = 1, 1, 1, 1.
- RESET_N low during the second WR of a LEN=4 copy -> outputs 0 immediately; exactly one destination word written; no DONE; a new START after reset completes normally.
